tnoc_vc_port_controller: RTL and testbench

TNOC_VC_PORT_CONTROLLER -- requirements
Module: tnoc_vc_port_controller

---
 rtl/tnoc_vc_port_controller_pkg.sv | 14 +
 rtl/tnoc_fifo.sv | 54 +++++
 rtl/tnoc_lock_arbiter.sv | 61 ++++++
 rtl/tnoc_vc_port_controller.sv | 93 +++++++++
 tb/tb_tnoc_vc_port_controller.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tnoc_vc_port_controller_pkg.sv
// rtl/tnoc_vc_port_controller_pkg.sv - shared tnoc types for VC/port arbitration
package tnoc_vc_port_controller_pkg;

   typedef enum logic {
      TNOC_VC_ARB_RR    = 1'b0,
      TNOC_VC_ARB_FIXED = 1'b1
   } tnoc_vc_arb_mode;

   // Index width that stays legal for a single-entry vector.
   function automatic int tnoc_idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/tnoc_fifo.sv
// rtl/tnoc_fifo.sv - small circular FIFO with zero-latency head and occupancy count
module tnoc_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic [WIDTH-1:0]           push_data,
   input  logic                       pop,
   output logic [WIDTH-1:0]           head_data,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             empty;
   logic             full;
   logic             do_pop;
   logic             do_push;

   assign empty     = (count == '0);
   assign full      = (count == CW'(DEPTH));
   assign do_pop    = pop & ~empty;
   assign do_push   = push & (~full | do_pop);
   assign head_data = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   assert property (@(posedge clk) disable iff (rst) !(push && full && !pop));

endmodule

// File: rtl/tnoc_lock_arbiter.sv
// rtl/tnoc_lock_arbiter.sv - round-robin/fixed arbiter that holds its winner until freed
module tnoc_lock_arbiter
   import tnoc_vc_port_controller_pkg::*;
#(
   parameter int              REQUESTS = 2,
   parameter tnoc_vc_arb_mode MODE     = TNOC_VC_ARB_RR
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [REQUESTS-1:0] request,
   input  logic [REQUESTS-1:0] free,
   output logic [REQUESTS-1:0] grant
);

   localparam int IW = tnoc_idx_width(REQUESTS);

   logic                locked;
   logic [REQUESTS-1:0] lock_grant;
   logic [REQUESTS-1:0] arb_grant;
   logic [REQUESTS-1:0] onehot;
   logic [IW-1:0]       start;
   logic [IW-1:0]       winner;
   logic [IW-1:0]       next_start;
   int                  cand;

   always_comb begin
      arb_grant = '0;
      winner    = '0;
      cand      = 0;
      onehot    = '0;
      for (int i = 0; i < REQUESTS; i++) begin
         cand   = (MODE == TNOC_VC_ARB_FIXED) ? i : (int'(start) + i) % REQUESTS;
         onehot = REQUESTS'(1) << cand;
         if (arb_grant == '0 && (request & onehot) != '0) begin
            arb_grant = onehot;
            winner    = IW'(cand);
         end
      end
   end

   assign next_start = (winner == IW'(REQUESTS - 1)) ? '0 : winner + 1'b1;
   assign grant      = locked ? lock_grant : arb_grant;

   // A winner freed in its own grant cycle never locks (single-flit packet).
   always_ff @(posedge clk) begin
      if (rst) begin
         locked     <= 1'b0;
         lock_grant <= '0;
         start      <= '0;
      end else if (locked) begin
         if ((free & lock_grant) != '0) locked <= 1'b0;
      end else if (arb_grant != '0) begin
         start <= next_start;
         if ((free & arb_grant) == '0) begin
            locked     <= 1'b1;
            lock_grant <= arb_grant;
         end
      end
   end

endmodule

// File: rtl/tnoc_vc_port_controller.sv
// rtl/tnoc_vc_port_controller.sv - per-VC port arbitration, VC arbitration and output grant FIFO
module tnoc_vc_port_controller
   import tnoc_vc_port_controller_pkg::*;
#(
   parameter int              PORTS       = 5,
   parameter int              CHANNELS    = 2,
   parameter int              GRANT_DEPTH = 2,
   parameter tnoc_vc_arb_mode VC_ARB_MODE = TNOC_VC_ARB_RR
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [PORTS*CHANNELS-1:0]        i_request,
   input  logic [PORTS*CHANNELS-1:0]        i_free,
   input  logic [CHANNELS-1:0]              i_vc_available,
   output logic [PORTS*CHANNELS-1:0]        o_grant,
   output logic [PORTS-1:0]                 o_output_grant,
   output logic [CHANNELS-1:0]              o_output_vc,
   input  logic                             i_output_free,
   output logic [$clog2(GRANT_DEPTH+1)-1:0] o_grant_count
);

   localparam int CW = $clog2(GRANT_DEPTH + 1);
   localparam int FW = PORTS + CHANNELS;

   logic [PORTS-1:0]    port_grant [CHANNELS];
   logic [CHANNELS-1:0] vc_request;
   logic [CHANNELS-1:0] vc_free;
   logic [CHANNELS-1:0] vc_grant;
   logic [PORTS-1:0]    push_port;
   logic                push;
   logic                fifo_room;
   logic [FW-1:0]       head;
   logic [CW-1:0]       count;

   assign fifo_room = (count < CW'(GRANT_DEPTH));

   for (genvar c = 0; c < CHANNELS; c++) begin : g_vc
      tnoc_lock_arbiter #(
         .REQUESTS (PORTS),
         .MODE     (TNOC_VC_ARB_RR)
      ) u_port_arb (
         .clk     (clk),
         .rst     (rst),
         .request (i_request[c*PORTS +: PORTS]),
         .free    (i_free[c*PORTS +: PORTS]),
         .grant   (port_grant[c])
      );

      assign vc_request[c] = (|(i_request[c*PORTS +: PORTS] & port_grant[c]))
                             & i_vc_available[c] & fifo_room;
      assign vc_free[c]    = |(i_free[c*PORTS +: PORTS] & port_grant[c]);
      assign o_grant[c*PORTS +: PORTS] = port_grant[c] & {PORTS{vc_grant[c]}};
   end

   // Once locked the VC grant ignores vc_request, so a full FIFO never preempts it.
   tnoc_lock_arbiter #(
      .REQUESTS (CHANNELS),
      .MODE     (VC_ARB_MODE)
   ) u_vc_arb (
      .clk     (clk),
      .rst     (rst),
      .request (vc_request),
      .free    (vc_free),
      .grant   (vc_grant)
   );

   assign push = |(vc_free & vc_grant);

   always_comb begin
      push_port = '0;
      for (int c = 0; c < CHANNELS; c++) begin
         if (vc_free[c] && vc_grant[c]) push_port = push_port | port_grant[c];
      end
   end

   tnoc_fifo #(
      .WIDTH (FW),
      .DEPTH (GRANT_DEPTH)
   ) u_grant_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data ({push_port, vc_grant}),
      .pop       (i_output_free),
      .head_data (head),
      .count     (count)
   );

   assign o_output_grant = head[FW-1 -: PORTS];
   assign o_output_vc    = head[CHANNELS-1:0];
   assign o_grant_count  = count;

endmodule

// File: tb/tb_tnoc_vc_port_controller.sv
// tb/tb_tnoc_vc_port_controller.sv - directed bench with a packet-level model for RR and FIXED instances
module tb_tnoc_vc_port_controller;
   import tnoc_vc_port_controller_pkg::*;

   localparam int P = 5;
   localparam int C = 2;
   localparam int D = 2;
   localparam int N = P * C;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [N-1:0] req = '0;
   logic [N-1:0] fr = '0;
   logic [C-1:0] avail = '1;
   logic         ofree = 1'b0;

   logic [N-1:0] d_grant [2];
   logic [P-1:0] d_og [2];
   logic [C-1:0] d_ov [2];
   logic [1:0]   d_cnt [2];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   tnoc_vc_port_controller #(
      .PORTS(P), .CHANNELS(C), .GRANT_DEPTH(D), .VC_ARB_MODE(TNOC_VC_ARB_RR)
   ) dut_rr (
      .clk(clk), .rst(rst), .i_request(req), .i_free(fr), .i_vc_available(avail),
      .o_grant(d_grant[0]), .o_output_grant(d_og[0]), .o_output_vc(d_ov[0]),
      .i_output_free(ofree), .o_grant_count(d_cnt[0])
   );

   tnoc_vc_port_controller #(
      .PORTS(P), .CHANNELS(C), .GRANT_DEPTH(D), .VC_ARB_MODE(TNOC_VC_ARB_FIXED)
   ) dut_fx (
      .clk(clk), .rst(rst), .i_request(req), .i_free(fr), .i_vc_available(avail),
      .o_grant(d_grant[1]), .o_output_grant(d_og[1]), .o_output_vc(d_ov[1]),
      .i_output_free(ofree), .o_grant_count(d_cnt[1])
   );

   // Model state: owner port per VC (-1 free), next search start, owning VC, grant queue.
   int plock [2][C];
   int pnext [2][C];
   int vlock [2];
   int vnext [2];
   int fq_p  [2][D+1];
   int fq_v  [2][D+1];
   int fq_n  [2];
   int e_pg  [2][C];
   int e_vg  [2];

   function automatic bit bit_at(input int vec, input int i);
      return ((vec >> i) & 1) == 1;
   endfunction

   task automatic model_eval(input int k, output int eg, output int eog, output int eov, output int ecnt);
      int v;
      for (int c = 0; c < C; c++) begin
         if (plock[k][c] >= 0) e_pg[k][c] = plock[k][c];
         else begin
            e_pg[k][c] = -1;
            for (int i = 0; i < P; i++) begin
               int p;
               p = (pnext[k][c] + i) % P;
               if (e_pg[k][c] < 0 && bit_at(int'(req), c * P + p)) e_pg[k][c] = p;
            end
         end
      end
      if (vlock[k] >= 0) e_vg[k] = vlock[k];
      else begin
         e_vg[k] = -1;
         for (int i = 0; i < C; i++) begin
            v = (k == 1) ? i : (vnext[k] + i) % C;
            if (e_vg[k] < 0 && e_pg[k][v] >= 0 && bit_at(int'(req), v * P + e_pg[k][v])
                && bit_at(int'(avail), v) && fq_n[k] < D) e_vg[k] = v;
         end
      end
      eg   = (e_vg[k] >= 0) ? (1 << (e_vg[k] * P + e_pg[k][e_vg[k]])) : 0;
      eog  = (fq_n[k] > 0) ? (1 << fq_p[k][0]) : 0;
      eov  = (fq_n[k] > 0) ? (1 << fq_v[k][0]) : 0;
      ecnt = fq_n[k];
   endtask

   task automatic model_step(input int k);
      int pushv;
      bit vf [C];
      if (rst) begin
         for (int c = 0; c < C; c++) begin
            plock[k][c] = -1;
            pnext[k][c] = 0;
         end
         vlock[k] = -1;
         vnext[k] = 0;
         fq_n[k]  = 0;
      end else begin
         for (int c = 0; c < C; c++)
            vf[c] = e_pg[k][c] >= 0 && bit_at(int'(fr), c * P + e_pg[k][c]);
         for (int c = 0; c < C; c++) begin
            if (plock[k][c] >= 0) begin
               if (vf[c]) plock[k][c] = -1;
            end else if (e_pg[k][c] >= 0) begin
               pnext[k][c] = (e_pg[k][c] + 1) % P;
               if (!vf[c]) plock[k][c] = e_pg[k][c];
            end
         end
         pushv = -1;
         if (vlock[k] >= 0) begin
            if (vf[vlock[k]]) begin
               pushv    = vlock[k];
               vlock[k] = -1;
            end
         end else if (e_vg[k] >= 0) begin
            vnext[k] = (e_vg[k] + 1) % C;
            if (vf[e_vg[k]]) pushv = e_vg[k];
            else vlock[k] = e_vg[k];
         end
         if (ofree && fq_n[k] > 0) begin
            for (int i = 0; i < D; i++) begin
               fq_p[k][i] = fq_p[k][i+1];
               fq_v[k][i] = fq_v[k][i+1];
            end
            fq_n[k]--;
         end
         if (pushv >= 0 && fq_n[k] < D) begin
            fq_p[k][fq_n[k]] = e_pg[k][pushv];
            fq_v[k][fq_n[k]] = pushv;
            fq_n[k]++;
         end
      end
   endtask

   task automatic mchk(input string name, input int k, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL model_%s inst=%0d dut=%0h model=%0h t=%0t", name, k, got, exp, $time);
      end
   endtask

   task automatic dchk(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s got=%0h expected=%0h t=%0t", name, got, exp, $time);
      end
   endtask

   always @(posedge clk) begin
      for (int k = 0; k < 2; k++) model_step(k);
   end

   always @(negedge clk) begin
      int eg, eog, eov, ecnt;
      for (int k = 0; k < 2; k++) begin
         model_eval(k, eg, eog, eov, ecnt);
         if (!rst) begin
            mchk("grant", k, int'(d_grant[k]), eg);
            mchk("out_grant", k, int'(d_og[k]), eog);
            mchk("out_vc", k, int'(d_ov[k]), eov);
            mchk("count", k, int'(d_cnt[k]), ecnt);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [N-1:0] r, input logic [N-1:0] f, input logic [C-1:0] a, input logic o);
      req   = r;
      fr    = f;
      avail = a;
      ofree = o;
      #1;
   endtask

   task automatic drain();
      for (int i = 0; i < D + 1; i++) begin
         tick();
         drive('0, '0, '1, 1'b1);
      end
      tick();
      drive('0, '0, '1, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [N-1:0] alt;
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      drive('0, '0, '1, 1'b0);
      dchk("reset_grant", int'(d_grant[0]), 0);
      dchk("reset_out_grant", int'(d_og[0]), 0);
      dchk("reset_out_vc", int'(d_ov[0]), 0);
      dchk("reset_count", int'(d_cnt[0]), 0);

      // Ports 1 and 3 on VC0
      tick(); drive(10'h00a, 10'h000, 2'b11, 1'b0);
      dchk("rr_first_port1", int'(d_grant[0]), 'h002);
      tick(); drive(10'h00a, 10'h002, 2'b11, 1'b0);
      dchk("port1_held", int'(d_grant[0]), 'h002);
      tick(); drive(10'h008, 10'h000, 2'b11, 1'b0);
      dchk("port3_next", int'(d_grant[0]), 'h008);
      dchk("head_port1", int'(d_og[0]), 'h02);
      dchk("head_vc0", int'(d_ov[0]), 'h1);
      dchk("count_one", int'(d_cnt[0]), 1);
      tick(); drive(10'h008, 10'h008, 2'b11, 1'b0);
      tick(); drive(10'h000, 10'h000, 2'b11, 1'b0);
      dchk("count_two", int'(d_cnt[0]), 2);
      dchk("head_still_port1", int'(d_og[0]), 'h02);
      tick(); drive(10'h000, 10'h000, 2'b11, 1'b1);
      tick(); drive(10'h000, 10'h000, 2'b11, 1'b0);
      dchk("head_port3_after_pop", int'(d_og[0]), 'h08);
      dchk("count_after_pop", int'(d_cnt[0]), 1);
      drain();

      // Single-flit packet, port 0 on VC1
      tick(); drive(10'h020, 10'h020, 2'b11, 1'b0);
      dchk("single_flit_grant", int'(d_grant[0]), 'h020);
      dchk("single_flit_count0", int'(d_cnt[0]), 0);
      tick(); drive(10'h000, 10'h000, 2'b11, 1'b0);
      dchk("single_flit_released", int'(d_grant[0]), 0);
      dchk("single_flit_count1", int'(d_cnt[0]), 1);
      dchk("single_flit_head_port", int'(d_og[0]), 'h01);
      dchk("single_flit_head_vc", int'(d_ov[0]), 'h2);
      drain();

      // Fill the FIFO with two packets, third must wait for a pop
      tick(); drive(10'h010, 10'h000, 2'b11, 1'b0);
      tick(); drive(10'h010, 10'h010, 2'b11, 1'b0);
      tick(); drive(10'h001, 10'h000, 2'b11, 1'b0);
      tick(); drive(10'h001, 10'h001, 2'b11, 1'b0);
      tick(); drive(10'h002, 10'h000, 2'b11, 1'b0);
      dchk("full_withheld", int'(d_grant[0]), 0);
      dchk("full_count", int'(d_cnt[0]), 2);
      tick(); drive(10'h002, 10'h000, 2'b11, 1'b1);
      dchk("full_pop_cycle", int'(d_grant[0]), 0);
      tick(); drive(10'h002, 10'h000, 2'b11, 1'b0);
      dchk("third_granted", int'(d_grant[0]), 'h002);
      dchk("third_count", int'(d_cnt[0]), 1);
      tick(); drive(10'h002, 10'h002, 2'b11, 1'b0);
      drain();

      // Both VCs continuously requesting single-flit packets from port 2
      for (int i = 0; i < 4; i++) begin
         tick(); drive(10'h084, 10'h084, 2'b11, 1'b1);
         alt = (i % 2 == 0) ? 10'h080 : 10'h004;
         dchk("rr_alternate", int'(d_grant[0]), int'(alt));
         dchk("fixed_vc0", int'(d_grant[1]), 'h004);
      end
      drain();

      // VC0 without credit, VC1 proceeds
      tick(); drive(10'h041, 10'h040, 2'b10, 1'b0);
      dchk("no_credit_vc1_wins", int'(d_grant[0]), 'h040);
      tick(); drive(10'h001, 10'h000, 2'b10, 1'b0);
      dchk("no_credit_blocked", int'(d_grant[0]), 0);
      avail = 2'b11;
      #1;
      dchk("credit_same_cycle", int'(d_grant[0]), 'h001);
      tick(); drive(10'h001, 10'h001, 2'b11, 1'b0);
      drain();

      // Reset while locked with one FIFO entry
      tick(); drive(10'h001, 10'h001, 2'b11, 1'b0);
      tick(); drive(10'h002, 10'h000, 2'b11, 1'b0);
      dchk("pre_reset_lock", int'(d_grant[0]), 'h002);
      dchk("pre_reset_count", int'(d_cnt[0]), 1);
      tick(); rst = 1'b1; drive(10'h000, 10'h000, 2'b11, 1'b0);
      tick(); rst = 1'b0; drive(10'h000, 10'h000, 2'b11, 1'b0);
      dchk("post_reset_grant", int'(d_grant[0]), 0);
      dchk("post_reset_out_grant", int'(d_og[0]), 0);
      dchk("post_reset_out_vc", int'(d_ov[0]), 0);
      dchk("post_reset_count", int'(d_cnt[0]), 0);
      tick(); drive(10'h009, 10'h000, 2'b11, 1'b0);
      dchk("post_reset_port0_first", int'(d_grant[0]), 'h001);
      tick(); drive(10'h009, 10'h001, 2'b11, 1'b0);
      tick(); drive(10'h000, 10'h000, 2'b11, 1'b0);
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
